// File: rtl/seven_segment_scan_decoder.sv
// seven_segment_scan_decoder: debounced readback of a 2-digit muxed 7-seg bus (clk/reset, segment_data/digit_sel/clr_err in; number/units/tens/valid/blank/error/err_sticky out)
module seven_segment_scan_decoder #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] segment_data,
  input  logic [1:0] digit_sel,
  input  logic       clr_err,
  output logic [6:0] number,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       valid,
  output logic       blank,
  output logic       error,
  output logic       err_sticky
);
  typedef enum logic {WAIT_UNITS, WAIT_TENS} state_t;
  state_t r_state, w_state_nx;
  logic [8:0] r_last;
  logic [3:0] r_run;
  logic [3:0] r_units_lat;
  logic       r_blank_lat;
  logic [8:0] w_pair;
  logic       w_same, w_accept, w_err, w_u, w_t, w_legal, w_blank_pat;
  logic [3:0] w_digit;
  logic [6:0] w_number;
  logic       w_unused;
  assign w_unused = segment_data[7];
  assign w_pair   = {segment_data[6:0], digit_sel};
  assign w_same   = w_pair == r_last;
  assign w_accept = w_same && r_run == 4'(STABLE_CYCLES - 1);
  always_comb begin
    w_digit     = 4'd0;
    w_legal     = 1'b1;
    w_blank_pat = 1'b0;
    case (segment_data[6:0])
      7'h3F: w_digit = 4'd0;
      7'h06: w_digit = 4'd1;
      7'h5B: w_digit = 4'd2;
      7'h4F: w_digit = 4'd3;
      7'h66: w_digit = 4'd4;
      7'h6D: w_digit = 4'd5;
      7'h7D: w_digit = 4'd6;
      7'h07: w_digit = 4'd7;
      7'h7F: w_digit = 4'd8;
      7'h6F: w_digit = 4'd9;
      7'h00: w_blank_pat = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end
  assign w_err    = w_accept && digit_sel != 2'b00 && (digit_sel == 2'b11 || !w_legal);
  assign w_u      = w_accept && digit_sel == 2'b01 && w_legal;
  assign w_t      = w_accept && digit_sel == 2'b10 && w_legal && r_state == WAIT_TENS;
  assign w_number = {3'b0, w_digit} * 7'd10 + {3'b0, r_units_lat};
  always_comb begin
    w_state_nx = w_err ? WAIT_UNITS : w_u ? WAIT_TENS : w_t ? WAIT_UNITS : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_UNITS;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= '0;
      r_run       <= '0;
      r_units_lat <= '0;
      r_blank_lat <= 1'b0;
      number      <= '0;
      units       <= '0;
      tens        <= '0;
      valid       <= 1'b0;
      blank       <= 1'b0;
      error       <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      r_last     <= w_pair;
      r_run      <= !w_same ? 4'd1 : r_run == 4'(STABLE_CYCLES) ? r_run : r_run + 4'd1;
      valid      <= w_t;
      error      <= w_err;
      err_sticky <= w_err | (err_sticky & ~clr_err);
      if (w_u) begin
        r_units_lat <= w_digit;
        r_blank_lat <= w_blank_pat;
      end
      if (w_t) begin
        units  <= r_units_lat;
        tens   <= w_digit;
        number <= w_number;
        blank  <= r_blank_lat & w_blank_pat;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb_seven_segment_scan_decoder: scoreboarded random/directed bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;
  localparam int S = 3;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_err = 1'b0;
  logic [7:0] segment_data = '0;
  logic [1:0] digit_sel = '0;
  logic [6:0] number;
  logic [3:0] units, tens;
  logic       valid, blank, error, err_sticky;
  seven_segment_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .segment_data(segment_data), .digit_sel(digit_sel),
    .clr_err(clr_err), .number(number), .units(units), .tens(tens), .valid(valid),
    .blank(blank), .error(error), .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  typedef struct {bit is_err; int num; int u; int t; bit blk;} ev_t;
  ev_t q[$];
  int checks = 0, failures = 0;
  int m_prev = 0, m_run = 0, m_u = 0, m_num = 0, m_units = 0, m_tens = 0;
  bit m_have_u = 0, m_ub = 0, m_blank = 0, m_sticky = 0;
  int pats[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  function automatic int decode(input int p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return p == 0 ? 10 : -1;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && (valid || error)) begin
      if (valid && error) chk("valid_and_error", 1, 0);
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_is_error", int'(error), int'(e.is_err));
        chk("number", int'(number), e.num);
        chk("units", int'(units), e.u);
        chk("tens", int'(tens), e.t);
        chk("blank", int'(blank), int'(e.blk));
      end
    end
  end
  task automatic rst();
    reset = 1'b1; segment_data = '0; digit_sel = '0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    m_prev = 0; m_run = 0; m_have_u = 0; m_num = 0; m_units = 0; m_tens = 0;
    m_blank = 0; m_sticky = 0;
    chk("rst_number", int'(number), 0);
    chk("rst_units", int'(units), 0);
    chk("rst_tens", int'(tens), 0);
    chk("rst_flags", int'({valid, blank, error, err_sticky}), 0);
    reset = 1'b0;
    #1;
  endtask
  task automatic hold(input logic [7:0] seg, input logic [1:0] sel, input int k, input bit clr);
    int pair, d;
    bit acc, last_edge, err_acc;
    pair = int'({seg[6:0], sel});
    err_acc = 0;
    if (pair == m_prev) begin
      acc = m_run < S && m_run + k >= S;
      last_edge = m_run + k == S;
      m_run = m_run + k > S ? S : m_run + k;
    end else begin
      acc = k >= S;
      last_edge = k == S;
      m_run = k > S ? S : k;
    end
    m_prev = pair;
    if (acc && sel != 2'b00) begin
      d = decode(int'(seg[6:0]));
      if (sel == 2'b11 || d < 0) begin
        err_acc = 1;
        m_have_u = 0;
        q.push_back('{1'b1, m_num, m_units, m_tens, m_blank});
      end else if (sel == 2'b01) begin
        m_have_u = 1;
        m_u = d == 10 ? 0 : d;
        m_ub = d == 10;
      end else if (m_have_u) begin
        m_units = m_u;
        m_tens = d == 10 ? 0 : d;
        m_num = m_tens * 10 + m_units;
        m_blank = m_ub && d == 10;
        m_have_u = 0;
        q.push_back('{1'b0, m_num, m_units, m_tens, m_blank});
      end
    end
    m_sticky = clr ? (err_acc && last_edge) : (m_sticky | err_acc);
    segment_data = seg; digit_sel = sel; clr_err = clr;
    repeat (k) @(negedge clk);
    #1;
    clr_err = 1'b0;
    chk("pending_pulse_missing", q.size(), 0);
    q.delete();
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
  endtask
  initial begin
    logic [7:0] seg;
    logic [1:0] sel;
    int r;
    rst();
    hold(8'h6D, 2'b01, 3, 0); hold(8'h00, 2'b00, 1, 0); hold(8'h66, 2'b10, 3, 0);
    hold(8'h4F, 2'b01, 2, 0); hold(8'h06, 2'b01, 3, 0); hold(8'h3F, 2'b10, 3, 0);
    hold(8'h5B, 2'b10, 3, 0); hold(8'h7F, 2'b01, 3, 0); hold(8'h6F, 2'b10, 3, 0);
    hold(8'h7F, 2'b01, 3, 0); hold(8'h01, 2'b10, 3, 0); hold(8'h00, 2'b00, 1, 1);
    hold(8'h00, 2'b01, 3, 0); hold(8'h00, 2'b10, 3, 0);
    hold(8'h66, 2'b01, 3, 0); hold(8'h66, 2'b11, 3, 0); hold(8'h3F, 2'b10, 3, 0);
    hold(8'h7F, 2'b01, 3, 0); hold(8'h02, 2'b10, 3, 1); hold(8'h00, 2'b00, 2, 1);
    hold(8'h06, 2'b01, 3, 0); rst(); hold(8'h5B, 2'b10, 3, 0);
    hold(8'h6F, 2'b01, 3, 0); hold(8'h07, 2'b10, 3, 0);
    hold(8'h86, 2'b01, 6, 0); hold(8'h07, 2'b10, 8, 0);
    hold(8'h00, 2'b01, 3, 0); hold(8'h4F, 2'b10, 3, 0);
    seg = 8'h00; sel = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 13);
        seg[6:0] = r < 10 ? 7'(pats[r]) : r == 10 ? 7'h00 : 7'($urandom_range(0, 127));
        seg[7] = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 7);
        sel = r < 3 ? 2'b01 : r < 6 ? 2'b10 : r == 6 ? 2'b00 : 2'b11;
      end
      hold(seg, sel, $urandom_range(1, 5), $urandom_range(0, 9) == 0);
    end
    chk("queue_empty_at_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Decodes a multiplexed two-digit seven-segment display bus back into a binary number.
- It is the inverse of the BCD-to-seven-segment encoder.
- It monitors segment lines plus one-hot digit strobes and filters glitches with a stability counter.
- It reassembles units and tens into a 0..99 value, flags undecodable patterns, and serves as the vending machine's display self-check and readback path.

Parameters:
- STABLE_CYCLES, 3, number of consecutive clock edges a (segment, strobe) pair must be sampled unchanged before it is accepted. Legal range 2..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- segment_data  input  8  segment bus; bit0=a .. bit6=g, bit7=decimal point (ignored)
- digit_sel  input  2  one-hot digit strobe; 2'b01 = units, 2'b10 = tens, 2'b00 = blanking gap
- clr_err  input  1  clears err_sticky
- number  output  7  decoded value tens*10+units, 0..99
- units  output  4  last accepted units digit
- tens  output  4  last accepted tens digit
- valid  output  1  one-cycle pulse: number/units/tens updated
- blank  output  1  both digits of the last frame were blank (pattern 0x00)
- error  output  1  one-cycle pulse: accepted pair was illegal
- err_sticky  output  1  set by error, held until clr_err or reset

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset.
- Reset values:
  - number, units, tens = 0.
  - valid, blank, error, err_sticky = 0.
  - FSM = WAIT_UNITS; run length = 0; last-sample register = 0.
- Stability filter:
  - Each edge, compare {segment_data[6:0], digit_sel} with the previously sampled pair.
  - Equal: run length increments, saturating at STABLE_CYCLES. Different: run length becomes 1.
  - A pair is accepted exactly once, at the edge where run length becomes STABLE_CYCLES.
  - A pair held longer is never re-accepted. A single-edge change restarts the count.
- Pattern decode (bit7 ignored):
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
  - 0x00 = blank, value 0.
  - Any other pattern is illegal.
- Accepted strobe handling:
  - digit_sel=2'b00: ignored, no state change.
  - digit_sel=2'b11: illegal.
- FSM states WAIT_UNITS and WAIT_TENS; transitions occur on the accept edge:
  - WAIT_UNITS, legal units pair: latch units value and blank bit internally; go to WAIT_TENS.
  - WAIT_UNITS, legal tens pair: ignored (resynchronisation); stay.
  - WAIT_TENS, legal units pair: overwrite latched units; stay.
  - WAIT_TENS, legal tens pair: on the same edge register the outputs below; go to WAIT_UNITS.
    - units and tens updated.
    - number = tens*10 + units, computed in 7 bits; max 99, no overflow.
    - blank = both digits blank.
    - valid = 1 for one cycle.
  - Any state, illegal pattern or strobe: error = 1 for one cycle, err_sticky = 1; discard the partial frame; go to WAIT_UNITS. number/units/tens are unchanged.
- Latency: a tens pair first sampled at edge N is accepted at edge N+STABLE_CYCLES-1. valid is high in the cycle after that edge, and the outputs are visible in that same cycle.
- Outputs hold their last value between valid pulses.
- Output timing:
  - valid and error never assert in the same cycle.
  - Each pulse lasts exactly one cycle, even when input is held.
- clr_err:
  - Clears err_sticky on the next edge.
  - If clr_err and a new error coincide, err_sticky ends at 1 (set wins).
- Reset mid-frame: partial digit discarded; the next frame must start with a units digit.
- A blank units digit with a legal tens digit is legal; it decodes to tens*10.

Test Plan:
- Reset, then units 0x6D (5) held 3 cycles, gap 00, tens 0x66 (4) held 3 cycles -> valid pulses 1 cycle, number=45, units=5, tens=4, blank=0.
- Units 0x4F held only 2 cycles, then 0x06 held 3 cycles, then tens 0x3F held 3 cycles -> glitch rejected; number=1, units=1, tens=0.
- Tens strobe 0x5B first, then units 0x7F, then tens 0x6F, each held 3 cycles -> first tens ignored; number=98, exactly one valid pulse.
- Units 0x7F, then tens with pattern 0x01 -> error 1-cycle pulse, err_sticky=1, no valid, number unchanged; assert clr_err -> err_sticky=0 next cycle.
- Both digits 0x00 held 3 cycles each -> valid, number=0, blank=1. Units 0x66 then digit_sel=2'b11 -> error, FSM returns to WAIT_UNITS.
- Assert reset between units and tens acceptance -> outputs zero. A following tens-only pair gives no valid; a full frame afterwards decodes correctly.
